fetch_stage: RTL and testbench

//  Fetch stage plus IF/ID register: owns PC, reads byte-wide instruction memory, assembles
//  1/2-byte instructions for Decode. Consumes Hazard_Unit outputs (stall_F/stall_D active-low

---
 rtl/fetch_stage.sv | 130 +++++++++++++
 tb/tb_fetch_stage.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: PC owner, byte-wide instruction fetch and IF/ID register.
// Assembles 1- or 2-byte instructions (opcode, then optional immediate byte)
// for Decode and accepts PC redirects from Execute (branch) and Memory (RET/RTI).
// Optional interrupt entry is compiled in when the macro FETCH_IRQ_EN is defined;
// without it irq is ignored and irq_ack / irq_ret_pc stay 0.
module fetch_stage #(
    parameter logic [7:0]  RESET_VECTOR  = 8'h00,
    parameter logic [15:0] TWO_BYTE_MASK = 16'h1000,
    parameter logic [7:0]  IRQ_VECTOR    = 8'h01
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       stall_F,
    input  logic       stall_D,
    input  logic       flush_D,
    input  logic       branch_taken_E,
    input  logic [7:0] branch_target_E,
    input  logic       pc_load_M,
    input  logic [7:0] pc_value_M,
    output logic [7:0] imem_addr,
    input  logic [7:0] imem_data,
    output logic [7:0] instr_D,
    output logic [7:0] imm_D,
    output logic [7:0] pc_plus_D,
    output logic       valid_D,
    output logic       is_2byte_D,
    input  logic       irq,
    output logic       irq_ack,
    output logic [7:0] irq_ret_pc
);

    // Assembly state: waiting for an opcode, or for the immediate that follows it.
    localparam logic [0:0] FETCH_OP  = 1'b0;
    localparam logic [0:0] FETCH_IMM = 1'b1;

    localparam logic [7:0] NOP_OPCODE = 8'h00;

    logic [7:0] r_pc;
    logic [7:0] r_instr;
    logic [7:0] r_imm;
    logic [7:0] r_pc_plus;
    logic       r_valid;
    logic [0:0] r_pending;
    logic       r_irq_ack;
    logic [7:0] r_irq_ret_pc;

    logic [7:0] w_pc_inc;
    logic       w_opcode_2byte;
    logic       w_irq_take;

    // PC increment wraps naturally at 8 bits (FF -> 00).
    assign w_pc_inc       = r_pc + 8'd1;
    assign w_opcode_2byte = TWO_BYTE_MASK[imem_data[7:4]];

`ifdef FETCH_IRQ_EN
    // Interrupt entry only in a clean opcode slot, so a 2-byte instruction is never split;
    // requiring irq_ack low makes a held irq re-enter at most every other cycle.
    assign w_irq_take = irq && !r_irq_ack && (r_pending == FETCH_OP) && stall_F && stall_D &&
                        !flush_D && !branch_taken_E && !pc_load_M;
`else
    // Interrupts compiled out: entry can never happen, ack and saved PC remain 0.
    assign w_irq_take = irq & 1'b0;
`endif

    // Prioritised PC / IF/ID update: redirects, flush, immediate completion, stall, fetch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc         <= RESET_VECTOR;
            r_instr      <= 8'h00;
            r_imm        <= 8'h00;
            r_pc_plus    <= 8'h00;
            r_valid      <= 1'b0;
            r_pending    <= FETCH_OP;
            r_irq_ack    <= 1'b0;
            r_irq_ret_pc <= 8'h00;
        end else begin
            r_irq_ack <= 1'b0;
            if (pc_load_M) begin
                r_pc      <= pc_value_M;
                r_instr   <= NOP_OPCODE;
                r_valid   <= 1'b0;
                r_pending <= FETCH_OP;
            end else if (branch_taken_E) begin
                r_pc      <= branch_target_E;
                r_instr   <= NOP_OPCODE;
                r_valid   <= 1'b0;
                r_pending <= FETCH_OP;
            end else if (flush_D) begin
                // With stall_F low (waiting on a return) the PC must not move.
                if (stall_F) begin
                    r_pc <= w_pc_inc;
                end
                r_instr   <= NOP_OPCODE;
                r_valid   <= 1'b0;
                r_pending <= FETCH_OP;
            end else if (r_pending == FETCH_IMM) begin
                // Hazard stalls are ignored here; the instruction must finish assembling.
                r_imm     <= imem_data;
                r_pc      <= w_pc_inc;
                r_pending <= FETCH_OP;
            end else if (!stall_F || !stall_D) begin
                r_pc <= r_pc;
            end else if (w_irq_take) begin
                r_pc         <= IRQ_VECTOR;
                r_irq_ret_pc <= r_pc;
                r_irq_ack    <= 1'b1;
                r_instr      <= NOP_OPCODE;
                r_valid      <= 1'b0;
                r_pending    <= FETCH_OP;
            end else begin
                r_instr   <= imem_data;
                r_pc_plus <= w_pc_inc;
                r_valid   <= 1'b1;
                r_imm     <= 8'h00;
                r_pending <= w_opcode_2byte ? FETCH_IMM : FETCH_OP;
                r_pc      <= w_pc_inc;
            end
        end
    end

    assign imem_addr  = r_pc;
    assign instr_D    = r_instr;
    assign imm_D      = r_imm;
    assign pc_plus_D  = r_pc_plus;
    assign valid_D    = r_valid;
    assign is_2byte_D = (r_pending == FETCH_IMM);
    assign irq_ack    = r_irq_ack;
    assign irq_ret_pc = r_irq_ret_pc;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios plus a randomized run against a
// behavioural model of the fetch stage. Honors FETCH_IRQ_EN like the design.
module tb_fetch_stage;

    logic       clk = 1'b0;
    logic       rst;
    logic       stall_F, stall_D, flush_D;
    logic       branch_taken_E;
    logic [7:0] branch_target_E;
    logic       pc_load_M;
    logic [7:0] pc_value_M;
    logic [7:0] imem_addr;
    logic [7:0] imem_data;
    logic [7:0] instr_D, imm_D, pc_plus_D;
    logic       valid_D, is_2byte_D;
    logic       irq, irq_ack;
    logic [7:0] irq_ret_pc;

    logic [7:0] mem [256];

    int total = 0;
    int bad   = 0;

    // Model state: the architectural view of the stage
    logic [7:0] m_pc, m_instr, m_imm, m_pcplus, m_ret;
    logic       m_valid, m_wait_imm, m_ack;

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr];

    fetch_stage dut (
        .clk(clk), .rst(rst),
        .stall_F(stall_F), .stall_D(stall_D), .flush_D(flush_D),
        .branch_taken_E(branch_taken_E), .branch_target_E(branch_target_E),
        .pc_load_M(pc_load_M), .pc_value_M(pc_value_M),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .instr_D(instr_D), .imm_D(imm_D), .pc_plus_D(pc_plus_D),
        .valid_D(valid_D), .is_2byte_D(is_2byte_D),
        .irq(irq), .irq_ack(irq_ack), .irq_ret_pc(irq_ret_pc)
    );

    function automatic bit is_two_byte(input logic [7:0] op);
        logic [15:0] mask;
        mask = 16'h1000;
        return mask[op[7:4]];
    endfunction

    task automatic model_reset();
        m_pc = 8'h00; m_instr = 8'h00; m_imm = 8'h00; m_pcplus = 8'h00;
        m_valid = 1'b0; m_wait_imm = 1'b0; m_ack = 1'b0; m_ret = 8'h00;
    endtask

    // One clock of the instruction-assembly rules, in priority order.
    task automatic model_step();
        logic [7:0] byte_in;
        bit irq_ok;
        bit ack_next;
        byte_in  = mem[m_pc];
        ack_next = 1'b0;
`ifdef FETCH_IRQ_EN
        irq_ok = irq && !m_ack;
`else
        irq_ok = 1'b0;
`endif
        if (pc_load_M || branch_taken_E) begin
            m_pc = pc_load_M ? pc_value_M : branch_target_E;
            m_instr = 8'h00; m_valid = 1'b0; m_wait_imm = 1'b0;
        end else if (flush_D) begin
            if (stall_F) m_pc = m_pc + 8'd1;
            m_instr = 8'h00; m_valid = 1'b0; m_wait_imm = 1'b0;
        end else if (m_wait_imm) begin
            m_imm = byte_in; m_pc = m_pc + 8'd1; m_wait_imm = 1'b0;
        end else if (!stall_F || !stall_D) begin
            // frozen
        end else if (irq_ok) begin
            m_ret = m_pc; m_pc = 8'h01; ack_next = 1'b1;
            m_instr = 8'h00; m_valid = 1'b0;
        end else begin
            m_instr = byte_in; m_pcplus = m_pc + 8'd1; m_valid = 1'b1; m_imm = 8'h00;
            m_wait_imm = is_two_byte(byte_in); m_pc = m_pc + 8'd1;
        end
        m_ack = ack_next;
    endtask

    // Advance model and DUT by one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall_F = 1'b1; stall_D = 1'b1; flush_D = 1'b0;
        branch_taken_E = 1'b0; branch_target_E = 8'h00;
        pc_load_M = 1'b0; pc_value_M = 8'h00; irq = 1'b0;
    endtask

    task automatic do_branch(input logic [7:0] tgt);
        branch_taken_E = 1'b1; branch_target_E = tgt;
        tick();
        branch_taken_E = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        total++;
        if (imem_addr !== 8'h00 || valid_D !== 1'b0 || instr_D !== 8'h00 || is_2byte_D !== 1'b0 || irq_ack !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: addr=%h valid=%b instr=%h pend=%b ack=%b want 00 0 00 0 0", imem_addr, valid_D, instr_D, is_2byte_D, irq_ack);
        end
        tick(); tick();
        // Mid-cycle assertion must clear state without waiting for a clock edge.
        #2 rst = 1'b1;
        #1;
        model_reset();
        total++;
        if (imem_addr !== 8'h00 || valid_D !== 1'b0 || is_2byte_D !== 1'b0 || instr_D !== 8'h00 || pc_plus_D !== 8'h00) begin
            bad++;
            $display("FAIL async_reset: addr=%h valid=%b pend=%b instr=%h pcplus=%h want 00 0 0 00 00", imem_addr, valid_D, is_2byte_D, instr_D, pc_plus_D);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        total++;
        if (imem_addr !== 8'h00) begin
            bad++;
            $display("FAIL reset_release: addr=%h want 00", imem_addr);
        end
    endtask

    task automatic test_stream();
        logic [7:0] exp_op [3];
        exp_op[0] = 8'h11; exp_op[1] = 8'h22; exp_op[2] = 8'h33;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (instr_D !== exp_op[i] || pc_plus_D !== 8'(i + 1) || valid_D !== 1'b1) begin
                bad++;
                $display("FAIL stream_%0d: instr=%h pcplus=%h valid=%b want %h %h 1", i, instr_D, pc_plus_D, valid_D, exp_op[i], 8'(i + 1));
            end
        end
    endtask

    task automatic test_two_byte();
        do_branch(8'h04);
        tick();
        total++;
        if (instr_D !== 8'hC5 || is_2byte_D !== 1'b1 || imem_addr !== 8'h05) begin
            bad++;
            $display("FAIL two_byte_op: instr=%h pend=%b pc=%h want C5 1 05", instr_D, is_2byte_D, imem_addr);
        end
        stall_F = 1'b0; stall_D = 1'b0;
        tick();
        stall_F = 1'b1; stall_D = 1'b1;
        total++;
        if (imm_D !== 8'h7A || is_2byte_D !== 1'b0 || imem_addr !== 8'h06 || instr_D !== 8'hC5) begin
            bad++;
            $display("FAIL two_byte_imm: imm=%h pend=%b pc=%h instr=%h want 7A 0 06 C5", imm_D, is_2byte_D, imem_addr, instr_D);
        end
        do_branch(8'hFF);
        tick();
        total++;
        if (instr_D !== 8'hC0 || is_2byte_D !== 1'b1 || imem_addr !== 8'h00 || pc_plus_D !== 8'h00) begin
            bad++;
            $display("FAIL wrap_op: instr=%h pend=%b pc=%h pcplus=%h want C0 1 00 00", instr_D, is_2byte_D, imem_addr, pc_plus_D);
        end
        tick();
        total++;
        if (imm_D !== 8'h11 || imem_addr !== 8'h01 || is_2byte_D !== 1'b0) begin
            bad++;
            $display("FAIL wrap_imm: imm=%h pc=%h pend=%b want 11 01 0", imm_D, imem_addr, is_2byte_D);
        end
    endtask

    task automatic test_branch_pending();
        do_branch(8'h04);
        tick();
        do_branch(8'h40);
        total++;
        if (imem_addr !== 8'h40 || valid_D !== 1'b0 || is_2byte_D !== 1'b0 || instr_D !== 8'h00) begin
            bad++;
            $display("FAIL branch_discard: pc=%h valid=%b pend=%b instr=%h want 40 0 0 00", imem_addr, valid_D, is_2byte_D, instr_D);
        end
        tick();
        total++;
        if (instr_D !== 8'h5E || pc_plus_D !== 8'h41 || valid_D !== 1'b1) begin
            bad++;
            $display("FAIL branch_next: instr=%h pcplus=%h valid=%b want 5E 41 1", instr_D, pc_plus_D, valid_D);
        end
    endtask

    task automatic test_ret();
        logic [7:0] held;
        held = imem_addr;
        flush_D = 1'b1; stall_F = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (imem_addr !== held || valid_D !== 1'b0) begin
                bad++;
                $display("FAIL ret_wait_%0d: pc=%h valid=%b want %h 0", i, imem_addr, valid_D, held);
            end
        end
        pc_load_M = 1'b1; pc_value_M = 8'h2A;
        tick();
        idle_inputs();
        total++;
        if (imem_addr !== 8'h2A || valid_D !== 1'b0) begin
            bad++;
            $display("FAIL ret_load: pc=%h valid=%b want 2A 0", imem_addr, valid_D);
        end
    endtask

    task automatic test_irq();
        do_branch(8'h10);
        tick();
        irq = 1'b1;
        tick();
        total++;
        if (imm_D !== 8'h55 || imem_addr !== 8'h12 || irq_ack !== 1'b0) begin
            bad++;
            $display("FAIL irq_imm_first: imm=%h pc=%h ack=%b want 55 12 0", imm_D, imem_addr, irq_ack);
        end
        tick();
        irq = 1'b0;
`ifdef FETCH_IRQ_EN
        total++;
        if (irq_ack !== 1'b1 || irq_ret_pc !== 8'h12 || imem_addr !== 8'h01 || valid_D !== 1'b0) begin
            bad++;
            $display("FAIL irq_entry: ack=%b ret=%h pc=%h valid=%b want 1 12 01 0", irq_ack, irq_ret_pc, imem_addr, valid_D);
        end
        tick();
        total++;
        if (irq_ack !== 1'b0) begin
            bad++;
            $display("FAIL irq_pulse: ack=%b want 0", irq_ack);
        end
`else
        total++;
        if (irq_ack !== 1'b0 || irq_ret_pc !== 8'h00 || imem_addr !== 8'h13 || instr_D !== 8'h20) begin
            bad++;
            $display("FAIL irq_ignored: ack=%b ret=%h pc=%h instr=%h want 0 00 13 20", irq_ack, irq_ret_pc, imem_addr, instr_D);
        end
`endif
    endtask

    task automatic test_random();
        logic [42:0] got, want;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'($urandom);
        end
        for (int c = 0; c < 400; c++) begin
            stall_F        = ($urandom_range(0, 9) != 0);
            stall_D        = ($urandom_range(0, 14) != 0);
            flush_D        = ($urandom_range(0, 9) == 0);
            branch_taken_E = ($urandom_range(0, 11) == 0);
            branch_target_E = 8'($urandom);
            pc_load_M      = ($urandom_range(0, 19) == 0);
            pc_value_M     = 8'($urandom);
            irq            = ($urandom_range(0, 4) == 0);
            tick();
            got  = {imem_addr, instr_D, imm_D, pc_plus_D, valid_D, is_2byte_D, irq_ack, irq_ret_pc};
            want = {m_pc, m_instr, m_imm, m_pcplus, m_valid, m_wait_imm, m_ack, m_ret};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL random_cycle_%0d: got pc=%h in=%h im=%h pp=%h v=%b p=%b a=%b r=%h want pc=%h in=%h im=%h pp=%h v=%b p=%b a=%b r=%h",
                         c, imem_addr, instr_D, imm_D, pc_plus_D, valid_D, is_2byte_D, irq_ack, irq_ret_pc,
                         m_pc, m_instr, m_imm, m_pcplus, m_valid, m_wait_imm, m_ack, m_ret);
            end
        end
        idle_inputs();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h00] = 8'h11; mem[8'h01] = 8'h22; mem[8'h02] = 8'h33;
        mem[8'h04] = 8'hC5; mem[8'h05] = 8'h7A;
        mem[8'hFF] = 8'hC0;
        mem[8'h40] = 8'h5E;
        mem[8'h10] = 8'hC3; mem[8'h11] = 8'h55; mem[8'h12] = 8'h20;
        test_reset();
        test_stream();
        test_two_byte();
        test_branch_pending();
        test_ret();
        test_irq();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
